// File: rtl/sie_pkg.sv
// Shared definitions for the SIE receive path: line states, PID codes, CRC constants, FSM states.
package sie_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [1:0] {
    CLS_SPECIAL   = 2'b00,
    CLS_TOKEN     = 2'b01,
    CLS_HANDSHAKE = 2'b10,
    CLS_DATA      = 2'b11
  } pid_class_t;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [2:0] {
    IDLE,
    RX_PID,
    RX_BODY,
    EOP_WAIT,
    DONE,
    ABORT
  } rx_state_t;

  function automatic logic pid_valid(input logic [7:0] pid);
    return pid[7:4] == ~pid[3:0];
  endfunction

endpackage

// File: rtl/sie_rx_crc_check.sv
// Serial CRC5/CRC16 checker: registers preset to all ones, residual compared after the CRC field.
module sie_rx_crc_check
  import sie_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic init,
  input  logic bit_en,
  input  logic bit_in,
  input  logic mode_crc16,
  output logic match
);

  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic        fb5;
  logic        fb16;

  assign fb5  = bit_in ^ crc5[4];
  assign fb16 = bit_in ^ crc16[15];

  // Both polynomials run in parallel; the mode only picks which residual counts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      crc5  <= '0;
      crc16 <= '0;
    end else if (init) begin
      crc5  <= '1;
      crc16 <= '1;
    end else if (bit_en) begin
      crc5  <= {crc5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
      crc16 <= {crc16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
    end
  end

  assign match = mode_crc16 ? (crc16 == CRC16_RESIDUAL) : (crc5 == CRC5_RESIDUAL);

endmodule

// File: rtl/sie_rx_packet_decoder.sv
// SIE receive packet engine: NRZI decode, SYNC hunt, unstuff, byte assembly, PID/CRC/EOP checks.
// IDLE: hunt SYNC | RX_PID: first byte | RX_BODY: payload+CRC | EOP_WAIT: SE0 SE0 J | DONE: pulse | ABORT: drain to EOP
module sie_rx_packet_decoder
  import sie_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned STUFF_LIMIT    = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       DP_line,
  input  logic       DM_line,
  output logic [7:0] parallel_op,
  output logic       byte_valid,
  output logic       Token_flag,
  output logic       Data_flag,
  output logic       Handshake_flag,
  output logic       Error_flag,
  output logic       crc_ok,
  output logic       packet_done
);

  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned BC_W   = $clog2(MAX_DATA_BYTES + 4);

  rx_state_t         state, state_nxt;
  logic [1:0]        line;
  logic              prev_j;
  logic [6:0]        hist;
  logic [ONES_W-1:0] ones;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [BC_W-1:0]   body_max;
  logic              se0_two;
  logic              abort_se0;

  logic       is_jk, cur_j, dbit, in_rx, stuff_slot, keep, stuff_err;
  logic       byte_full, sync_hit, pid_ok, overrun, eop_good, crc_match;
  logic       has_crc, eop_err;
  logic [7:0] new_byte;
  pid_class_t pid_cls;

  assign line       = {DP_line, DM_line};
  assign is_jk      = (line == LS_J) || (line == LS_K);
  assign cur_j      = (line == LS_J);
  assign dbit       = (cur_j == prev_j);
  assign in_rx      = (state == RX_PID) || (state == RX_BODY);
  assign stuff_slot = (ones == ONES_W'(STUFF_LIMIT));
  assign keep       = in_rx && is_jk && !stuff_slot;
  assign stuff_err  = in_rx && is_jk && stuff_slot && dbit;
  assign byte_full  = keep && (bit_cnt == 3'd7);
  assign new_byte   = {dbit, shreg[7:1]};
  assign sync_hit   = (state == IDLE) && is_jk && ({hist, dbit} == 8'h01);
  assign pid_cls    = pid_class_t'(new_byte[1:0]);
  assign pid_ok     = pid_valid(new_byte) && (pid_cls != CLS_SPECIAL);
  assign overrun    = (state == RX_BODY) && byte_full && (byte_cnt == body_max);
  assign eop_good   = (state == EOP_WAIT) && (line == LS_J) && se0_two;
  assign has_crc    = Token_flag || Data_flag;
  assign eop_err    = !(Token_flag || Data_flag || Handshake_flag) || (bit_cnt != 3'd0) ||
                      (has_crc && (!crc_match || (byte_cnt < BC_W'(2))));
  assign packet_done = (state == DONE);

  always_comb begin
    body_max = BC_W'(MAX_DATA_BYTES + 2);
    if (Token_flag)
      body_max = BC_W'(2);
    else if (Handshake_flag)
      body_max = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (sync_hit) state_nxt = RX_PID;
      RX_PID, RX_BODY: begin
        if (line == LS_SE1 || stuff_err)
          state_nxt = ABORT;
        else if (line == LS_SE0)
          state_nxt = EOP_WAIT;
        else if (byte_full && state == RX_PID)
          state_nxt = pid_ok ? RX_BODY : ABORT;
        else if (overrun)
          state_nxt = ABORT;
      end
      EOP_WAIT:
        if (line == LS_J)
          state_nxt = se0_two ? DONE : ABORT;
        else if (line != LS_SE0)
          state_nxt = ABORT;
      DONE:
        state_nxt = (line == LS_SE1) ? ABORT : IDLE;
      ABORT:
        if (line == LS_J && abort_se0) state_nxt = DONE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_j         <= 1'b1;
      hist           <= '1;
      ones           <= '0;
      shreg          <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      se0_two        <= 1'b0;
      abort_se0      <= 1'b0;
      parallel_op    <= '0;
      byte_valid     <= 1'b0;
      Token_flag     <= 1'b0;
      Data_flag      <= 1'b0;
      Handshake_flag <= 1'b0;
      Error_flag     <= 1'b0;
      crc_ok         <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (is_jk) prev_j <= cur_j;
      if (state == IDLE && is_jk) hist <= {hist[5:0], dbit};
      // Idle J decodes as 1s, so refilling with ones keeps stale packet bits from faking a SYNC.
      if (state == DONE) hist <= '1;

      if (sync_hit) begin
        Token_flag     <= 1'b0;
        Data_flag      <= 1'b0;
        Handshake_flag <= 1'b0;
        Error_flag     <= 1'b0;
        crc_ok         <= 1'b0;
        bit_cnt        <= '0;
        byte_cnt       <= '0;
        shreg          <= '0;
        ones           <= ONES_W'(1);
      end

      if (in_rx && is_jk) begin
        if (stuff_slot || !dbit)
          ones <= '0;
        else
          ones <= ones + ONES_W'(1);
      end

      if (keep) begin
        shreg   <= new_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_full) begin
          parallel_op <= new_byte;
          byte_valid  <= 1'b1;
          if (state == RX_BODY) byte_cnt <= byte_cnt + BC_W'(1);
        end
      end

      if (state == RX_PID && byte_full && pid_ok) begin
        Token_flag     <= (pid_cls == CLS_TOKEN);
        Data_flag      <= (pid_cls == CLS_DATA);
        Handshake_flag <= (pid_cls == CLS_HANDSHAKE);
      end

      if (in_rx)
        se0_two <= 1'b0;
      else if (state == EOP_WAIT && line == LS_SE0)
        se0_two <= 1'b1;

      if (state != ABORT || line == LS_K)
        abort_se0 <= 1'b0;
      else if (line == LS_SE0)
        abort_se0 <= 1'b1;

      if (state_nxt == ABORT && state != ABORT)
        Error_flag <= 1'b1;

      if (eop_good) begin
        crc_ok     <= has_crc && crc_match;
        Error_flag <= eop_err;
      end
    end
  end

  sie_rx_crc_check u_crc (
    .clock      (clock),
    .reset      (reset),
    .init       (sync_hit),
    .bit_en     (keep && (state == RX_BODY)),
    .bit_in     (dbit),
    .mode_crc16 (Data_flag),
    .match      (crc_match)
  );

endmodule

// File: tb/tb_sie_rx_packet_decoder.sv
// Directed + randomized packet bench with a bit-level transmit model (CRC, stuffing, NRZI, EOP).
module tb_sie_rx_packet_decoder;
  import sie_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       DP_line = 1'b1;
  logic       DM_line = 1'b0;
  logic [7:0] parallel_op;
  logic       byte_valid, Token_flag, Data_flag, Handshake_flag, Error_flag, crc_ok, packet_done;

  sie_rx_packet_decoder #(.MAX_DATA_BYTES(64), .STUFF_LIMIT(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .DP_line        (DP_line),
    .DM_line        (DM_line),
    .parallel_op    (parallel_op),
    .byte_valid     (byte_valid),
    .Token_flag     (Token_flag),
    .Data_flag      (Data_flag),
    .Handshake_flag (Handshake_flag),
    .Error_flag     (Error_flag),
    .crc_ok         (crc_ok),
    .packet_done    (packet_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [7:0] got[$];
  int         done_cnt = 0;

  always @(negedge clock) begin
    if (byte_valid) got.push_back(parallel_op);
    if (packet_done) done_cnt++;
  end

  bit         raw[$];
  logic [1:0] lines[$];
  logic [7:0] exp_b[$];
  int         got_base, done_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_pkt();
    raw.delete();
    lines.delete();
    exp_b.delete();
  endtask

  task automatic add_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) raw.push_back(v[i]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    add_bits({8'h00, b}, 8);
  endtask

  // CRC over everything after the PID, appended complemented, high bit first.
  task automatic add_crc5();
    logic [4:0] c = 5'h1F;
    bit fb;
    for (int i = 8; i < raw.size(); i++) begin
      fb = raw[i] ^ c[4];
      c = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    end
    for (int i = 4; i >= 0; i--) raw.push_back(~c[i]);
  endtask

  task automatic add_crc16();
    logic [15:0] c = 16'hFFFF;
    bit fb;
    for (int i = 8; i < raw.size(); i++) begin
      fb = raw[i] ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
  endtask

  task automatic encode(input bit flip_stuff);
    bit   full[$];
    int   ones = 0;
    bit   lvl = 1'b1;
    bit   flipped = 1'b0;
    logic [7:0] b;
    exp_b.delete();
    for (int i = 0; i < raw.size() / 8; i++) begin
      for (int k = 0; k < 8; k++) b[k] = raw[i*8 + k];
      exp_b.push_back(b);
    end
    for (int i = 0; i < 7; i++) full.push_back(1'b0);
    full.push_back(1'b1);
    foreach (raw[i]) full.push_back(raw[i]);
    lines.delete();
    foreach (full[i]) begin
      if (!full[i]) lvl = ~lvl;
      lines.push_back(lvl ? LS_J : LS_K);
      ones = full[i] ? ones + 1 : 0;
      if (ones == 6) begin
        if (!(flip_stuff && !flipped)) lvl = ~lvl;
        flipped = flipped | flip_stuff;
        lines.push_back(lvl ? LS_J : LS_K);
        ones = 0;
      end
    end
    lines.push_back(LS_SE0);
    lines.push_back(LS_SE0);
    lines.push_back(LS_J);
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      DP_line = 1'b1;
      DM_line = 1'b0;
    end
  endtask

  task automatic run_pkt(input string tag, input logic t, input logic d, input logic h,
                         input logic e, input logic c, input bit check_bytes);
    logic [7:0] obs;
    got_base  = got.size();
    done_base = done_cnt;
    foreach (lines[i]) begin
      @(negedge clock);
      {DP_line, DM_line} = lines[i];
    end
    drive_idle(4);
    chk($sformatf("%s.done", tag), done_cnt - done_base, 1);
    chk($sformatf("%s.token", tag), Token_flag, t);
    chk($sformatf("%s.data", tag), Data_flag, d);
    chk($sformatf("%s.hs", tag), Handshake_flag, h);
    chk($sformatf("%s.err", tag), Error_flag, e);
    chk($sformatf("%s.crc", tag), crc_ok, c);
    if (check_bytes) begin
      chk($sformatf("%s.nbytes", tag), got.size() - got_base, exp_b.size());
      foreach (exp_b[i]) begin
        obs = (got_base + i < got.size()) ? got[got_base + i] : 8'hxx;
        chk($sformatf("%s.byte%0d", tag, i), obs, exp_b[i]);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s.pop", tag), parallel_op, 0);
    chk($sformatf("%s.bv", tag), byte_valid, 0);
    chk($sformatf("%s.flags", tag), {Token_flag, Data_flag, Handshake_flag}, 0);
    chk($sformatf("%s.err", tag), Error_flag, 0);
    chk($sformatf("%s.crc", tag), crc_ok, 0);
    chk($sformatf("%s.pd", tag), packet_done, 0);
  endtask

  initial begin
    int kind, len;
    drive_idle(3);
    chk_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    drive_idle(5);

    new_pkt(); add_byte(PID_ACK); encode(0);
    run_pkt("ack", 0, 0, 1, 0, 0, 1);

    new_pkt(); add_byte(PID_IN); add_bits(16'h16, 7); add_bits(16'h6, 4); add_crc5(); encode(0);
    run_pkt("in", 1, 0, 0, 0, 1, 1);

    new_pkt(); add_byte(PID_OUT); add_bits(16'h05, 7); add_bits(16'hA, 4); add_crc5(); encode(0);
    run_pkt("out", 1, 0, 0, 0, 1, 1);

    new_pkt(); add_byte(PID_DATA0); add_byte(8'h62); add_crc16(); encode(0);
    run_pkt("data0", 0, 1, 0, 0, 1, 1);

    new_pkt(); add_byte(PID_DATA0); add_byte(8'h62); add_crc16();
    raw[raw.size() - 3] = ~raw[raw.size() - 3];
    encode(0);
    run_pkt("crcflip", 0, 1, 0, 1, 0, 1);

    new_pkt(); add_byte(PID_DATA0); add_byte(8'hFF); add_byte(8'hFF); add_crc16(); encode(0);
    run_pkt("stuff", 0, 1, 0, 0, 1, 1);

    new_pkt(); add_byte(PID_DATA0); add_byte(8'hFF); add_byte(8'hFF); add_crc16(); encode(1);
    run_pkt("stufferr", 0, 1, 0, 1, 0, 0);

    new_pkt(); add_byte(8'hD3); encode(0);
    run_pkt("badpid", 0, 0, 0, 1, 0, 0);

    new_pkt(); add_byte(PID_DATA0); add_byte(8'h5A); add_byte(8'h3C); add_crc16(); encode(0);
    lines[20] = LS_SE1;
    run_pkt("se1", 0, 1, 0, 1, 0, 0);

    new_pkt(); add_byte(PID_DATA0);
    for (int i = 0; i < 64; i++) add_byte(8'($urandom));
    add_crc16(); encode(0);
    run_pkt("maxlen", 0, 1, 0, 0, 1, 1);

    new_pkt(); add_byte(PID_DATA0);
    for (int i = 0; i < 65; i++) add_byte(8'($urandom));
    add_crc16(); encode(0);
    run_pkt("overrun", 0, 1, 0, 1, 0, 0);

    for (int n = 0; n < 8; n++) begin
      kind = $urandom_range(0, 2);
      new_pkt();
      if (kind == 0) begin
        add_byte(PID_DATA0);
        len = $urandom_range(0, 6);
        for (int i = 0; i < len; i++) add_byte(8'($urandom));
        add_crc16(); encode(0);
        run_pkt($sformatf("rnd%0d.data", n), 0, 1, 0, 0, 1, 1);
      end else if (kind == 1) begin
        add_byte($urandom_range(0, 1) != 0 ? PID_IN : PID_OUT);
        add_bits(16'($urandom_range(0, 127)), 7);
        add_bits(16'($urandom_range(0, 15)), 4);
        add_crc5(); encode(0);
        run_pkt($sformatf("rnd%0d.tok", n), 1, 0, 0, 0, 1, 1);
      end else begin
        add_byte(PID_ACK); encode(0);
        run_pkt($sformatf("rnd%0d.ack", n), 0, 0, 1, 0, 0, 1);
      end
    end

    new_pkt(); add_byte(PID_DATA0);
    for (int i = 0; i < 4; i++) add_byte(8'($urandom));
    add_crc16(); encode(0);
    done_base = done_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      {DP_line, DM_line} = lines[i];
    end
    @(negedge clock);
    reset = 1'b0;
    DP_line = 1'b1;
    DM_line = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk_all_zero("midreset");
    drive_idle(6);
    chk("midreset.nodone", done_cnt - done_base, 0);

    new_pkt(); add_byte(PID_ACK); encode(0);
    run_pkt("ack2", 0, 0, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sie_rx_packet_decoder.md
Name: sie_rx_packet_decoder

Overview:
Receive-side packet engine of the SIE. It is the counterpart of the transmit chain (PISO, PID, CRC, bit-stuff, NRZI, DP/DM).
- Samples DP/DM once per clock (1 bit/clock, same rate as the transmitter).
- Performs NRZI decode, SYNC detection, bit unstuffing, LSB-first byte assembly, PID validation, CRC5/CRC16 check and EOP detection.
- Presents bytes and packet-class flags to the SIPO/host side.

Parameters:
MAX_DATA_BYTES, 64, maximum DATA payload bytes, excluding PID and CRC16; longer packets flag an error.
STUFF_LIMIT, 6, number of consecutive 1s after which a stuffed 0 is expected.

Ports:
clock  in  1  system clock (26 MHz), single domain
reset  in  1  synchronous, active-low reset
DP_line  in  1  USB D+ sample
DM_line  in  1  USB D- sample
parallel_op  out  8  last assembled byte, LSB = first received bit
byte_valid  out  1  one-cycle pulse when parallel_op updates
Token_flag  out  1  current packet PID class is token
Data_flag  out  1  current packet PID class is data
Handshake_flag  out  1  current packet PID class is handshake
Error_flag  out  1  PID, stuff, CRC, length, SE1 or alignment error in current packet
crc_ok  out  1  CRC residual matched at EOP (token/data only)
packet_done  out  1  one-cycle pulse at the end of every packet (good or bad)

Behaviour:
- Reset (reset=0 at a clock edge): all outputs 0, FSM=IDLE, previous line state=J, shift and CRC registers cleared. Reset mid-packet abandons the packet with no packet_done.
- Line states: J=(DP=1,DM=0); K=(0,1); SE0=(0,0); SE1=(1,1).
- NRZI decode: decoded bit=1 if the line state equals the previous J/K state, 0 if it changed. SE0 does not update the previous state.
- IDLE: shift decoded bits into an 8-bit history. On history (oldest to newest) = 0,0,0,0,0,0,0,1 (K J K J K J K K), go to RX_PID. Clear the flags, Error_flag, crc_ok, bit counter, byte counter and ones counter. Unstuffing is active from the SYNC's final 1 onward.
- Unstuff in RX_PID/RX_BODY:
  - Count consecutive decoded 1s.
  - After STUFF_LIMIT ones, drop the next bit.
  - If that dropped bit is 1, it is a stuff error: go to ABORT.
- Byte assembly: shift right into the byte register; after 8 kept bits, parallel_op <= byte and byte_valid=1 for one cycle. Latency is 1 clock after the 8th kept bit's sample.
- RX_PID, first byte:
  - Require pid[7:4] == ~pid[3:0]; otherwise ABORT.
  - Classify pid[1:0]: 01 sets Token_flag, 11 sets Data_flag, 10 sets Handshake_flag, 00 (special) goes to ABORT.
  - Then go to RX_BODY.
- RX_BODY: feed every kept bit after the PID to the CRC checker. Byte-count limits after the PID:
  - token: exactly 2;
  - handshake: 0;
  - data: 2 to MAX_DATA_BYTES+2.
  - Overrun goes to ABORT immediately.
- SE0 in RX_PID/RX_BODY: go to EOP_WAIT. In EOP_WAIT:
  - second SE0 then J: go to DONE;
  - J right after a single SE0: ABORT;
  - K: ABORT.
- DONE, one cycle:
  - packet_done=1.
  - crc_ok = residual match: CRC5 residual 5'b01100, CRC16 residual 16'h800D; handshake gives crc_ok=0.
  - Error_flag=1 if any of: residual mismatch (token/data), bit count not byte-aligned, or byte count below minimum.
  - Then go to IDLE.
- ABORT: Error_flag=1. Ignore bits until SE0 followed by J, then pulse packet_done and go to IDLE.
- SE1 in any non-IDLE state: ABORT. SE1 in IDLE is ignored.
- Class flags, Error_flag and crc_ok hold their value until the next SYNC or reset.
- A SYNC pattern inside a packet body is plain data and does not restart the FSM.

Decomposition:
- Shared package sie_pkg:
  - line-state encodings J/K/SE0/SE1;
  - PID class codes and the four PID values used by the bench (OUT 0xE1, IN 0x69, DATA0 0xC3, ACK 0xD2);
  - CRC5 polynomial 5'h05 with residual 5'h0C;
  - CRC16 polynomial 16'h8005 with residual 16'h800D;
  - FSM state enum IDLE/RX_PID/RX_BODY/EOP_WAIT/DONE/ABORT.
- One sub-module, sie_rx_crc_check: serial CRC5/CRC16 checker with init-to-all-ones, a mode select and residual-compare output.

Test Plan:
- ACK: SYNC, PID 0xD2, SE0 SE0 J -> byte_valid with parallel_op=0xD2; Handshake_flag=1; packet_done once; Error_flag=0; crc_ok=0.
- IN token: SYNC, 0x69, two address/endp/CRC5 bytes from the bench model (address 0x16, endpoint 0x6), EOP -> three byte_valid pulses; Token_flag=1; crc_ok=1; Error_flag=0.
- DATA0: SYNC, 0xC3, payload 0x62, CRC16 from the model, EOP -> parallel_op sequence 0xC3, 0x62, then the CRC bytes; Data_flag=1; crc_ok=1. Repeat with one CRC bit flipped -> crc_ok=0, Error_flag=1.
- Stuffing: DATA0 payload 0xFF,0xFF transmitted with stuffed zeros -> bytes 0xFF,0xFF, no error. Inject a 1 in place of a stuffed 0 -> Error_flag=1, packet_done after the following EOP.
- Bad PID 0xD3 -> Error_flag=1, no class flag set. SE1 mid-body -> Error_flag=1.
- Drive reset=0 for one clock mid-DATA0 -> all outputs 0 on the next cycle, no packet_done. A following ACK packet decodes cleanly.
